// File: rtl/core_boot_loader_if.sv
// Load-stream interface for core_boot_loader: valid/ready word stream.
// master = stream source, slave = loader.
interface core_boot_loader_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/core_boot_loader.sv
// Boot loader: decodes header/payload stream into ROM/SRAM/REG writes and releases the core on GO.
// Optional feature: BOOT_LOADER_CHECKSUM_EN adds a trailing XOR checksum word per non-GO block.
module core_boot_loader #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ROM_AW  = 8,
  parameter int unsigned SRAM_AW = 10,
  parameter int unsigned REG_AW  = 3
) (
  input  logic               clk,
  input  logic               rstn,
  core_boot_loader_if.slave  ld,
  output logic               rom_we,
  output logic [ROM_AW-1:0]  rom_addr,
  output logic [DATA_W-1:0]  rom_wdata,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  output logic               reg_we,
  output logic [REG_AW-1:0]  reg_addr,
  output logic [DATA_W-1:0]  reg_wdata,
  output logic               core_rstn,
  output logic [ROM_AW-1:0]  pc_init,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    S_HDR,
    S_DATA,
`ifdef BOOT_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_RUN
  } state_t;

  localparam logic [1:0]  TGT_ROM  = 2'b00;
  localparam logic [1:0]  TGT_SRAM = 2'b01;
  localparam logic [1:0]  TGT_GO   = 2'b11;
  localparam logic [15:0] ROM_MASK  = 16'((32'd1 << ROM_AW) - 32'd1);
  localparam logic [15:0] SRAM_MASK = 16'((32'd1 << SRAM_AW) - 32'd1);
  localparam logic [15:0] REG_MASK  = 16'((32'd1 << REG_AW) - 32'd1);
  localparam logic [16:0] ROM_LIM   = 17'(32'd1 << ROM_AW);
  localparam logic [16:0] SRAM_LIM  = 17'(32'd1 << SRAM_AW);
  localparam logic [16:0] REG_LIM   = 17'(32'd1 << REG_AW);

  state_t      r_state, w_next;
  logic        r_ready;
  logic [1:0]  r_tgt;
  logic [13:0] r_left;
  logic [16:0] r_addr;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
`endif

  logic        w_xfer;
  logic [1:0]  w_tgt;
  logic [13:0] w_cnt;
  logic [15:0] w_base;
  logic [16:0] w_base_t;
  logic        w_in_range;

  assign ld.in_ready = r_ready;
  assign w_xfer      = ld.in_valid & r_ready;
  assign w_tgt       = ld.in_data[31:30];
  assign w_cnt       = ld.in_data[29:16];
  assign w_base      = ld.in_data[15:0];

  // r_addr is 17 bits so base+i never wraps; out-of-range is a plain compare.
  always_comb begin
    w_base_t   = '0;
    w_in_range = 1'b0;
    case (w_tgt)
      TGT_ROM:  w_base_t = {1'b0, w_base & ROM_MASK};
      TGT_SRAM: w_base_t = {1'b0, w_base & SRAM_MASK};
      default:  w_base_t = {1'b0, w_base & REG_MASK};
    endcase
    case (r_tgt)
      TGT_ROM:  w_in_range = (r_addr < ROM_LIM);
      TGT_SRAM: w_in_range = (r_addr < SRAM_LIM);
      default:  w_in_range = (r_addr < REG_LIM);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_HDR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR: begin
        if (w_xfer) begin
          if (w_tgt == TGT_GO) begin
            if (!err) w_next = S_RUN;
          end else if (w_cnt != 14'd0) begin
            w_next = S_DATA;
          end
`ifdef BOOT_LOADER_CHECKSUM_EN
          else begin
            w_next = S_CSUM;
          end
`endif
        end
      end
      S_DATA: begin
        if (w_xfer && (r_left == 14'd1)) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          w_next = S_CSUM;
`else
          w_next = S_HDR;
`endif
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      S_CSUM: if (w_xfer) w_next = S_HDR;
`endif
      S_RUN:   w_next = S_RUN;
      default: w_next = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ready    <= 1'b0;
      r_tgt      <= '0;
      r_left     <= '0;
      r_addr     <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_wdata  <= '0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      reg_we     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      core_rstn  <= 1'b0;
      pc_init    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      rom_we  <= 1'b0;
      sram_we <= 1'b0;
      reg_we  <= 1'b0;
      r_ready <= (w_next != S_RUN);
      case (r_state)
        S_HDR: begin
          if (w_xfer) begin
            r_tgt  <= w_tgt;
            r_left <= w_cnt;
            r_addr <= w_base_t;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_csum <= ld.in_data;
`endif
            if ((w_tgt == TGT_GO) && !err) begin
              core_rstn <= 1'b1;
              done      <= 1'b1;
              pc_init   <= w_base[ROM_AW-1:0];
            end
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_left <= r_left - 14'd1;
            r_addr <= r_addr + 17'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ ld.in_data;
`endif
            if (!w_in_range) begin
              err <= 1'b1;
            end else begin
              case (r_tgt)
                TGT_ROM: begin
                  rom_we    <= 1'b1;
                  rom_addr  <= r_addr[ROM_AW-1:0];
                  rom_wdata <= ld.in_data;
                end
                TGT_SRAM: begin
                  sram_we    <= 1'b1;
                  sram_addr  <= r_addr[SRAM_AW-1:0];
                  sram_wdata <= ld.in_data;
                end
                default: begin
                  reg_we    <= 1'b1;
                  reg_addr  <= r_addr[REG_AW-1:0];
                  reg_wdata <= ld.in_data;
                end
              endcase
            end
          end
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_xfer && (ld.in_data != r_csum)) err <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_boot_loader.sv
// Scoreboard bench for core_boot_loader: driver pushes expected writes, a monitor pops on each we pulse.
module tb_core_boot_loader;
  logic        clk = 1'b0;
  logic        rstn;
  logic        rom_we, sram_we, reg_we;
  logic [7:0]  rom_addr;
  logic [9:0]  sram_addr;
  logic [2:0]  reg_addr;
  logic [31:0] rom_wdata, sram_wdata, reg_wdata;
  logic        core_rstn, done, err;
  logic [7:0]  pc_init;

  core_boot_loader_if #(.DATA_W(32)) ld ();

  core_boot_loader #(.DATA_W(32), .ROM_AW(8), .SRAM_AW(10), .REG_AW(3)) dut (
    .clk(clk), .rstn(rstn), .ld(ld),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .core_rstn(core_rstn), .pc_init(pc_init), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] csum;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every we pulse must match the oldest expected write, in the right cycle.
  initial begin
    exp_t e;
    int   nwe, k, a;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      nwe = int'(rom_we) + int'(sram_we) + int'(reg_we);
      if (nwe != 0) begin
        n_cmp++;
        k = rom_we ? 0 : (sram_we ? 1 : 2);
        a = rom_we ? int'(rom_addr) : (sram_we ? int'(sram_addr) : int'(reg_addr));
        d = rom_we ? rom_wdata : (sram_we ? sram_wdata : reg_wdata);
        if (nwe > 1) begin
          n_fail++;
          $display("FAIL we_onehot: got %0d write enables high want 1", nwe);
        end else if (q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected: got kind=%0d addr=%0d data=%h want no write", k, a, d);
        end else begin
          e = q.pop_front();
          if (k != e.kind || a != e.addr || d !== e.data || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL wr: got kind=%0d addr=%0d data=%h cyc=%0d want kind=%0d addr=%0d data=%h cyc=%0d",
                     k, a, d, cyc, e.kind, e.addr, e.data, e.cyc);
          end
        end
      end else if (q.size() != 0 && q[0].cyc < cyc) begin
        n_cmp++;
        n_fail++;
        e = q.pop_front();
        $display("FAIL wr_missing: got no write want kind=%0d addr=%0d data=%h cyc=%0d",
                 e.kind, e.addr, e.data, e.cyc);
      end
    end
  end

  task automatic send(input logic [31:0] w, input bit push, input int kind, input int addr);
    bit rdy, ok;
    ok = 1'b0;
    ld.in_valid = 1'b1;
    ld.in_data  = w;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      rdy = ld.in_ready;
      @(posedge clk);
      #1;
      ok = rdy;
    end
    ld.in_valid = 1'b0;
    if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
    else if (push) q.push_back('{kind, addr, w, cyc});
  endtask

  task automatic hdr(input logic [31:0] w);
    csum = w;
    send(w, 1'b0, 0, 0);
  endtask

  task automatic pay(input logic [31:0] w, input bit push, input int kind, input int addr);
    csum = csum ^ w;
    send(w, push, kind, addr);
  endtask

  task automatic end_block(input bit corrupt);
`ifdef BOOT_LOADER_CHECKSUM_EN
    send(corrupt ? ~csum : csum, 1'b0, 0, 0);
`else
    if (corrupt) csum = ~csum;
`endif
  endtask

  task automatic idle(input int n);
    ld.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ld.in_valid = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ld.in_ready), 32'd0);
    chk("rst_we", {29'd0, rom_we, sram_we, reg_we}, 32'd0);
    chk("rst_addr", {11'd0, rom_addr, sram_addr, reg_addr}, 32'd0);
    chk("rst_wdata", rom_wdata | sram_wdata | reg_wdata, 32'd0);
    chk("rst_core_rstn", 32'(core_rstn), 32'd0);
    chk("rst_pc_init", 32'(pc_init), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready_after", 32'(ld.in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rom_v[5];
    logic [31:0] reg_v[8];
    rom_v = '{32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3, 32'h0020C1B3};
    reg_v = '{32'd1, 32'd2, 32'd3, 32'd4, 32'h66666666, 32'h7E6E76EE, 32'd600, 32'd100};
    ld.in_valid = 1'b0;
    ld.in_data  = '0;
    rstn = 1'b0;
    csum = '0;
    do_reset();

    // ROM base 0 cnt 5, back-to-back
    hdr(32'h0005_0000);
    for (int i = 0; i < 5; i++) pay(rom_v[i], 1'b1, 0, i);
    end_block(1'b0);

    // REG base 0 cnt 8
    hdr(32'h8008_0000);
    for (int i = 0; i < 8; i++) pay(reg_v[i], 1'b1, 2, i);
    end_block(1'b0);
    idle(2);
    chk("reg_err", 32'(err), 32'd0);

    // SRAM base 600 cnt 1, then GO base 0
    hdr(32'h4001_0258);
    pay(32'h8000_0000, 1'b1, 1, 600);
    end_block(1'b0);
    send(32'hC000_0000, 1'b0, 0, 0);
    chk("go_core_rstn", 32'(core_rstn), 32'd1);
    chk("go_done", 32'(done), 32'd1);
    chk("go_pc_init", 32'(pc_init), 32'd0);
    idle(1);
    chk("run_in_ready", 32'(ld.in_ready), 32'd0);
    idle(2);

    // ROM base 254 cnt 4: only 254, 255 written, err set, GO ignored
    do_reset();
    hdr(32'h0004_00FE);
    pay(32'hA0A0_0001, 1'b1, 0, 254);
    pay(32'hA0A0_0002, 1'b1, 0, 255);
    pay(32'hA0A0_0003, 1'b0, 0, 0);
    pay(32'hA0A0_0004, 1'b0, 0, 0);
    end_block(1'b0);
    idle(1);
    chk("oob_err", 32'(err), 32'd1);
    send(32'hC000_0010, 1'b0, 0, 0);
    idle(1);
    chk("oob_go_core_rstn", 32'(core_rstn), 32'd0);
    chk("oob_go_done", 32'(done), 32'd0);
    chk("oob_go_ready", 32'(ld.in_ready), 32'd1);
    hdr(32'h0001_0003);
    pay(32'h0000_BEEF, 1'b1, 0, 3);
    end_block(1'b0);
    idle(2);

    // toggled in_valid mid-block, then reset mid-block
    do_reset();
    hdr(32'h8004_0002);
    pay(32'h0000_0011, 1'b1, 2, 2);
    idle(1);
    pay(32'h0000_0022, 1'b1, 2, 3);
    idle(1);
    pay(32'h0000_0033, 1'b1, 2, 4);
    idle(2);
    do_reset();
    hdr(32'h4001_0005);
    pay(32'h0000_ABCD, 1'b1, 1, 5);
    end_block(1'b0);
    send(32'hC000_002A, 1'b0, 0, 0);
    chk("go2_core_rstn", 32'(core_rstn), 32'd1);
    chk("go2_pc_init", 32'(pc_init), 32'h2A);
    chk("go2_done", 32'(done), 32'd1);
    idle(2);

`ifdef BOOT_LOADER_CHECKSUM_EN
    do_reset();
    hdr(32'h8001_0001);
    pay(32'h1234_5678, 1'b1, 2, 1);
    end_block(1'b0);
    idle(1);
    chk("csum_ok_err", 32'(err), 32'd0);
    hdr(32'h8001_0002);
    pay(32'h0BAD_F00D, 1'b1, 2, 2);
    end_block(1'b1);
    idle(1);
    chk("csum_bad_err", 32'(err), 32'd1);
    send(32'hC000_0000, 1'b0, 0, 0);
    idle(1);
    chk("csum_go_core_rstn", 32'(core_rstn), 32'd0);
    idle(2);
`endif

    idle(3);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
